// File: rtl/vram_bus_arbiter_if.sv
// Bus bundle between the video fetch port, the CPU bus port, the SDRAM request port and the arbiter.
// master: arbiter view (drives acks, read data, SDRAM requests and the error flag).
// slave:  environment view (requesters and SDRAM controller).
interface vram_bus_arbiter_if;
  // video fetch port
  logic        vid_req;
  logic [18:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  // CPU bus port
  logic        cpu_rd_req;
  logic        cpu_wr_req;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  // SDRAM request port
  logic        mem_ready;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  // status
  logic        arb_err;

  modport master (
    input  vid_req, vid_addr, cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata,
           mem_ready, mem_ack, mem_rdata,
    output vid_ack, vid_data, cpu_ack, cpu_rdata,
           mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_be, arb_err
  );

  modport slave (
    output vid_req, vid_addr, cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata,
           mem_ready, mem_ack, mem_rdata,
    input  vid_ack, vid_data, cpu_ack, cpu_rdata,
           mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_be, arb_err
  );
endinterface

// File: rtl/vram_bus_arbiter.sv
// Shares the single SDRAM word port between video fetch and CPU, one byte transaction at a time.
// Latency: request seen in IDLE -> mem req next cycle -> requester ack 1 cycle after mem_ack (min 3).
// Backpressure: requesters hold a level req until their 1-cycle ack; SDRAM stalls by withholding mem_ack.
// Ports: CLK_200, reset_n (sync, active-low), bus (vram_bus_arbiter_if.master: vid_*, cpu_*, mem_*, arb_err).
// Option: define ARB_ROUND_ROBIN_EN for alternating tie-break instead of video priority + CPU starvation guard.
module vram_bus_arbiter #(
  parameter int CPU_MAX_WAIT = 4,   // 1..15
  parameter int ACK_TIMEOUT  = 255  // 1..255
) (
  input  logic               CLK_200,
  input  logic               reset_n,
  vram_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_XFER, ST_DONE} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(ACK_TIMEOUT);

  state_t      state_q, state_d;
  logic        owner_cpu_q, owner_cpu_d;
  logic        wr_q, wr_d;
  logic        lane_q, lane_d;
  logic        mask_q, mask_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        mem_rd_req_q, mem_rd_req_d;
  logic        mem_wr_req_q, mem_wr_req_d;
  logic [17:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic        vid_ack_q, vid_ack_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        arb_err_q, arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_cpu_q, last_cpu_d;
`else
  localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);
  logic [3:0]  wait_q, wait_d;
`endif

  logic        cpu_pend;
  logic        grant_vid, grant_cpu;
  logic [18:0] sel_addr;
  logic        sel_wr;
  logic        xfer_end;
  logic [7:0]  rd_byte, ret_byte;

  assign cpu_pend = bus.cpu_rd_req | bus.cpu_wr_req;
  assign rd_byte  = lane_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];

  // Tie-break between the two ports; only consulted in IDLE.
  always_comb begin
    grant_vid = bus.vid_req;
    grant_cpu = cpu_pend;
    if (bus.vid_req && cpu_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_cpu = !last_cpu_q;
      grant_vid = last_cpu_q;
`else
      // CPU forced through once video has been granted WAIT_MAX times over it
      grant_cpu = (wait_q == WAIT_MAX);
      grant_vid = !grant_cpu;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_cpu_d  = owner_cpu_q;
    wr_d         = wr_q;
    lane_d       = lane_q;
    mask_d       = 1'b0;
    tmo_d        = tmo_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    vid_ack_d    = 1'b0;
    vid_data_d   = vid_data_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    arb_err_d    = arb_err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_cpu_d   = last_cpu_q;
`else
    wait_d       = wait_q;
`endif
    sel_addr = grant_cpu ? bus.cpu_addr : bus.vid_addr;
    sel_wr   = grant_cpu & bus.cpu_wr_req;  // write wins over a simultaneous read
    xfer_end = bus.mem_ack || ((tmo_q + 8'd1) == TMO_LIMIT);
    ret_byte = bus.mem_ack ? rd_byte : 8'hFF;

    case (state_q)
      ST_INIT: begin
        if (bus.mem_ready) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        // mask_q marks the cycle right after an ack: the finished owner's level may still be
        // up, so no arbitration happens until it has had a cycle to drop it.
        if (!mask_q && (grant_vid || grant_cpu)) begin
          state_d      = ST_XFER;
          owner_cpu_d  = grant_cpu;
          wr_d         = sel_wr;
          lane_d       = sel_addr[0];
          tmo_d        = 8'd0;
          mem_rd_req_d = !sel_wr;
          mem_wr_req_d = sel_wr;
          mem_addr_d   = sel_addr[18:1];
          mem_be_d     = sel_addr[0] ? 2'b10 : 2'b01;
          mem_wdata_d  = sel_wr ? {bus.cpu_wdata, bus.cpu_wdata} : 16'h0000;
`ifdef ARB_ROUND_ROBIN_EN
          last_cpu_d   = grant_cpu;
`else
          if (grant_cpu)
            wait_d = 4'd0;
          else if (cpu_pend && wait_q != WAIT_MAX)
            wait_d = wait_q + 4'd1;
`endif
        end
      end
      ST_XFER: begin
        tmo_d = tmo_q + 8'd1;
        if (xfer_end) begin
          // mem_ack wins over a timeout landing in the same cycle
          state_d      = ST_DONE;
          mem_rd_req_d = 1'b0;
          mem_wr_req_d = 1'b0;
          if (!bus.mem_ack) arb_err_d = 1'b1;
          if (owner_cpu_q) begin
            cpu_ack_d = 1'b1;
            if (!wr_q) cpu_rdata_d = ret_byte;
          end else begin
            vid_ack_d  = 1'b1;
            vid_data_d = ret_byte;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mask_d  = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK_200) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      owner_cpu_q  <= 1'b0;
      wr_q         <= 1'b0;
      lane_q       <= 1'b0;
      mask_q       <= 1'b0;
      tmo_q        <= 8'd0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= 18'd0;
      mem_wdata_q  <= 16'd0;
      mem_be_q     <= 2'b00;
      vid_ack_q    <= 1'b0;
      vid_data_q   <= 8'd0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= 8'd0;
      arb_err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_cpu_q   <= 1'b1;
`else
      wait_q       <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      owner_cpu_q  <= owner_cpu_d;
      wr_q         <= wr_d;
      lane_q       <= lane_d;
      mask_q       <= mask_d;
      tmo_q        <= tmo_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      vid_ack_q    <= vid_ack_d;
      vid_data_q   <= vid_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      arb_err_q    <= arb_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_cpu_q   <= last_cpu_d;
`else
      wait_q       <= wait_d;
`endif
    end
  end

  assign bus.mem_rd_req = mem_rd_req_q;
  assign bus.mem_wr_req = mem_wr_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.vid_ack    = vid_ack_q;
  assign bus.vid_data   = vid_data_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.arb_err    = arb_err_q;
endmodule

// File: tb/tb_vram_bus_arbiter.sv
// Directed bench for vram_bus_arbiter: init/reset, video read, CPU write, arbitration order,
// ack timeout with late ack, and reset in the middle of a transfer.
module tb_vram_bus_arbiter;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  vram_bus_arbiter_if bus();

  vram_bus_arbiter #(.CPU_MAX_WAIT(4), .ACK_TIMEOUT(255)) dut (
    .CLK_200 (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int vid_acks = 0;
  int cpu_acks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus and sampling happens on the falling edge; ack pulses are counted here.
  task automatic tick();
    @(negedge clk);
    if (bus.vid_ack === 1'b1) vid_acks++;
    if (bus.cpu_ack === 1'b1) cpu_acks++;
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, bus.vid_ack, bus.vid_data, bus.cpu_ack, bus.cpu_rdata,
            bus.mem_rd_req, bus.mem_wr_req, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.arb_err};
  endfunction

  task automatic wait_req(input int limit, output int waited, output bit seen);
    waited = 0;
    while (!(bus.mem_rd_req === 1'b1 || bus.mem_wr_req === 1'b1) && waited < limit) begin
      tick();
      waited++;
    end
    seen = (bus.mem_rd_req === 1'b1 || bus.mem_wr_req === 1'b1);
  endtask

  initial begin
    logic [63:0] acc;
    logic        unstable;
    logic [9:0]  order;
    logic [9:0]  exp_order;
    int          waited;
    bit          seen;
    int          cnt;
    int          v0, c0;

    reset_n        = 1'b0;
    bus.vid_req    = 1'b1;
    bus.vid_addr   = 19'h00A01;
    bus.cpu_rd_req = 1'b0;
    bus.cpu_wr_req = 1'b0;
    bus.cpu_addr   = 19'h0;
    bus.cpu_wdata  = 8'h0;
    bus.mem_ready  = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 16'h0;

    // 1: reset for 4 cycles, then 10 cycles without mem_ready
    acc = 64'd0;
    for (int i = 0; i < 4; i++) begin tick(); acc |= all_outs(); end
    check_eq("reset_outputs_zero", acc, 64'd0);
    reset_n = 1'b1;
    acc = 64'd0;
    for (int i = 0; i < 10; i++) begin tick(); acc |= all_outs(); end
    check_eq("not_ready_outputs_zero", acc, 64'd0);
    bus.mem_ready = 1'b1;
    tick();
    check_eq("ready_seen_no_req_yet", bus.mem_rd_req, 1'b0);
    tick();
    check_eq("vid_rd_req_rises", bus.mem_rd_req, 1'b1);

    // 2: video read, byte lane 1
    check_eq("vid_mem_addr", bus.mem_addr, 18'h00500);
    check_eq("vid_mem_be", bus.mem_be, 2'b10);
    check_eq("vid_no_wr_req", bus.mem_wr_req, 1'b0);
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      unstable |= (bus.mem_rd_req !== 1'b1) || (bus.mem_addr !== 18'h00500) || (bus.mem_be !== 2'b10);
    end
    check_eq("vid_xfer_stable", unstable, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    check_eq("vid_ack_pulse", bus.vid_ack, 1'b1);
    check_eq("vid_data_hi_byte", bus.vid_data, 8'hBE);
    check_eq("vid_req_dropped", bus.mem_rd_req, 1'b0);
    bus.vid_req = 1'b0;
    tick();
    check_eq("vid_ack_one_cycle", bus.vid_ack, 1'b0);
    check_eq("vid_ack_count", vid_acks, 1);

    // 3: CPU write, byte lane 0
    bus.cpu_wr_req = 1'b1; bus.cpu_addr = 19'h01234; bus.cpu_wdata = 8'h5A;
    wait_req(10, waited, seen);
    check_eq("cpu_wr_req_seen", seen, 1'b1);
    check_eq("cpu_wr_is_write", {bus.mem_wr_req, bus.mem_rd_req}, 2'b10);
    check_eq("cpu_wr_addr", bus.mem_addr, 18'h0091A);
    check_eq("cpu_wr_wdata", bus.mem_wdata, 16'h5A5A);
    check_eq("cpu_wr_be", bus.mem_be, 2'b01);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check_eq("cpu_wr_ack", bus.cpu_ack, 1'b1);
    bus.cpu_wr_req = 1'b0;
    tick();
    check_eq("cpu_ack_count", cpu_acks, 1);
    check_eq("vid_ack_count_unchanged", vid_acks, 1);

    // 4: both ports requesting continuously
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00010;
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 19'h00021;
    v0 = vid_acks; c0 = cpu_acks;
    order = 10'd0;
    for (int i = 0; i < 10; i++) begin
      wait_req(20, waited, seen);
      check_eq("arb_req_seen", seen, 1'b1);
      order[i] = (bus.mem_addr === 18'h00010);
      bus.mem_ack = 1'b1; bus.mem_rdata = 16'h3C96;
      tick();
      bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    end
    bus.vid_req = 1'b0; bus.cpu_rd_req = 1'b0;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 10'b1010101010;
    check_eq("arb_vid_acks", vid_acks - v0, 5);
    check_eq("arb_cpu_acks", cpu_acks - c0, 5);
`else
    exp_order = 10'b1000010000;
    check_eq("arb_vid_acks", vid_acks - v0, 8);
    check_eq("arb_cpu_acks", cpu_acks - c0, 2);
`endif
    check_eq("arb_grant_order", order, exp_order);
    check_eq("arb_vid_data_lo", bus.vid_data, 8'h96);
    check_eq("arb_cpu_rdata_hi", bus.cpu_rdata, 8'h3C);

    // 5: mem_ack never comes
    bus.cpu_rd_req = 1'b1; bus.cpu_addr = 19'h00100;
    c0 = cpu_acks;
    wait_req(10, waited, seen);
    check_eq("tmo_req_seen", seen, 1'b1);
    cnt = 0;
    while (bus.mem_rd_req === 1'b1 && cnt < 400) begin tick(); cnt++; end
    check_eq("tmo_cycles_in_xfer", cnt, 255);
    check_eq("tmo_cpu_ack", bus.cpu_ack, 1'b1);
    check_eq("tmo_cpu_rdata", bus.cpu_rdata, 8'hFF);
    check_eq("tmo_arb_err", bus.arb_err, 1'b1);
    bus.cpu_rd_req = 1'b0;
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    acc = 64'd0;
    for (int i = 0; i < 4; i++) begin tick(); acc |= {62'd0, bus.mem_rd_req, bus.mem_wr_req}; end
    check_eq("late_ack_no_req", acc, 64'd0);
    check_eq("late_ack_no_extra_ack", cpu_acks - c0, 1);
    check_eq("late_ack_rdata_kept", bus.cpu_rdata, 8'hFF);
    check_eq("arb_err_sticky", bus.arb_err, 1'b1);

    // 6: reset two cycles into a transfer, then a stray mem_ack
    bus.vid_req = 1'b1; bus.vid_addr = 19'h00202;
    v0 = vid_acks;
    wait_req(10, waited, seen);
    check_eq("rst_req_seen", seen, 1'b1);
    tick();
    reset_n = 1'b0;
    tick();
    check_eq("rst_outputs_zero", all_outs(), 64'd0);
    bus.mem_ready = 1'b0;
    reset_n = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    acc = 64'd0;
    for (int i = 0; i < 5; i++) begin tick(); acc |= {62'd0, bus.mem_rd_req, bus.vid_ack}; end
    check_eq("rst_stays_init", acc, 64'd0);
    check_eq("rst_no_vid_ack", vid_acks - v0, 0);
    bus.mem_ready = 1'b1;
    wait_req(10, waited, seen);
    check_eq("rst_init_to_req_cycles", waited, 2);
    check_eq("rst_new_addr", bus.mem_addr, 18'h00101);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h00C7;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    check_eq("rst_recover_ack", bus.vid_ack, 1'b1);
    check_eq("rst_recover_data", bus.vid_data, 8'hC7);
    bus.vid_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
